// File: rtl/posit_div_pkg.sv
// Shared definitions for the posit divider front-end: FSM state encoding and
// width-generic NaR / zero helpers (operand words are zero-extended to NMAX).
package posit_div_pkg;

  // Widest posit word the helpers support; callers zero-extend narrower words.
  localparam int unsigned NMAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } ctrl_state_e;

  function automatic logic [NMAX-1:0] word_mask(input int unsigned n);
    logic [NMAX-1:0] m;
    if (n >= NMAX) m = '1;
    else           m = (NMAX'(1) << n) - NMAX'(1);
    return m;
  endfunction

  function automatic logic [NMAX-1:0] nar_word(input int unsigned n);
    return NMAX'(1) << (n - 1);
  endfunction

  function automatic logic [NMAX-1:0] zero_word(input int unsigned n);
    return nar_word(n) & ~word_mask(n);
  endfunction

  function automatic logic is_nar(input logic [NMAX-1:0] word, input int unsigned n);
    return (word & word_mask(n)) == nar_word(n);
  endfunction

  function automatic logic is_zero(input logic [NMAX-1:0] word, input int unsigned n);
    return (word & word_mask(n)) == zero_word(n);
  endfunction

endpackage

// File: rtl/posit_operand_fifo.sv
// Operand-pair FIFO: registered storage, extra-bit pointers that wrap naturally,
// simultaneous push and pop allowed.
module posit_operand_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/posit_div_issue_ctrl.sv
// Front-end for bct_posit_div: buffers operand pairs, resolves NaR/zero cases
// locally, issues the rest to the divider one at a time and guards with a watchdog.
module posit_div_issue_ctrl
  import posit_div_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_q,
  output logic         out_inf,
  output logic         out_zero,
  output logic         out_timeout,
  output logic [N-1:0] div_in1,
  output logic [N-1:0] div_in2,
  output logic         div_start,
  input  logic [N-1:0] div_out,
  input  logic         div_inf,
  input  logic         div_zero,
  input  logic         div_done,
  output logic         busy
);

  localparam int unsigned     WDW     = $clog2(TIMEOUT) + 1;
  localparam logic [N-1:0]    NAR     = N'(nar_word(N));
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*N-1:0] fifo_rdata;
  logic [N-1:0]   head_a, head_b;
  logic           a_nar, b_nar, a_zero, b_zero;

  ctrl_state_e    state_q, state_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [N-1:0]   div_in1_q, div_in1_d;
  logic [N-1:0]   div_in2_q, div_in2_d;
  logic [N-1:0]   res_q_q, res_q_d;
  logic           res_inf_q, res_inf_d;
  logic           res_zero_q, res_zero_d;
  logic           res_to_q, res_to_d;

  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  posit_operand_fifo #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .wdata_i ({in_a, in_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_a, head_b} = fifo_rdata;
  assign a_nar  = is_nar(NMAX'(head_a), N);
  assign b_nar  = is_nar(NMAX'(head_b), N);
  assign a_zero = is_zero(NMAX'(head_a), N);
  assign b_zero = is_zero(NMAX'(head_b), N);

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    div_in1_d  = div_in1_q;
    div_in2_d  = div_in2_q;
    res_q_d    = res_q_q;
    res_inf_d  = res_inf_q;
    res_zero_d = res_zero_q;
    res_to_d   = res_to_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (a_nar || b_nar || b_zero) begin
            res_q_d    = NAR;
            res_inf_d  = 1'b1;
            res_zero_d = 1'b0;
            res_to_d   = 1'b0;
            state_d    = ST_OUT;
          end else if (a_zero) begin
            res_q_d    = '0;
            res_inf_d  = 1'b0;
            res_zero_d = 1'b1;
            res_to_d   = 1'b0;
            state_d    = ST_OUT;
          end else begin
            div_in1_d = head_a;
            div_in2_d = head_b;
            state_d   = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end

      // wdog_q==0 marks the first WAIT cycle, where a leftover done level is ignored.
      ST_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if ((wdog_q != '0) && div_done) begin
          res_q_d    = div_out;
          res_inf_d  = div_inf;
          res_zero_d = div_zero;
          res_to_d   = 1'b0;
          state_d    = ST_OUT;
        end else if (wdog_q == WD_LAST) begin
          res_q_d    = NAR;
          res_inf_d  = 1'b1;
          res_zero_d = 1'b0;
          res_to_d   = 1'b1;
          state_d    = ST_OUT;
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          res_inf_d  = 1'b0;
          res_zero_d = 1'b0;
          res_to_d   = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wdog_q     <= '0;
      div_in1_q  <= '0;
      div_in2_q  <= '0;
      res_q_q    <= '0;
      res_inf_q  <= 1'b0;
      res_zero_q <= 1'b0;
      res_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      div_in1_q  <= div_in1_d;
      div_in2_q  <= div_in2_d;
      res_q_q    <= res_q_d;
      res_inf_q  <= res_inf_d;
      res_zero_q <= res_zero_d;
      res_to_q   <= res_to_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign out_valid   = (state_q == ST_OUT);
  assign out_q       = res_q_q;
  assign out_inf     = res_inf_q;
  assign out_zero    = res_zero_q;
  assign out_timeout = res_to_q;
  assign div_in1     = div_in1_q;
  assign div_in2     = div_in2_q;
  assign div_start   = (state_q == ST_ISSUE);
  assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_posit_div_issue_ctrl.sv
// Bench for posit_div_issue_ctrl: directed scenarios plus a randomized burst,
// checked against an arrival-order expectation queue and a divider response log.
module tb_posit_div_issue_ctrl;

  localparam int unsigned N       = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [31:0] NAR     = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic        out_inf, out_zero, out_timeout;
  logic [31:0] div_in1, div_in2;
  logic        div_start;
  logic [31:0] div_out = '0;
  logic        div_inf = 1'b0;
  logic        div_zero = 1'b0;
  logic        div_done = 1'b0;
  logic        busy;

  posit_div_issue_ctrl #(
    .N       (N),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_q       (out_q),
    .out_inf     (out_inf),
    .out_zero    (out_zero),
    .out_timeout (out_timeout),
    .div_in1     (div_in1),
    .div_in2     (div_in2),
    .div_start   (div_start),
    .div_out     (div_out),
    .div_inf     (div_inf),
    .div_zero    (div_zero),
    .div_done    (div_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vec = 0;
  int unsigned miscmp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          is_div;
    logic [31:0] q;
    bit          inf;
    bit          zero;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  typedef struct {
    bit          to;
    logic [31:0] q;
    bit          inf;
    bit          zero;
    logic [31:0] a;
    logic [31:0] b;
  } dlog_t;

  exp_t  exp_q[$];
  dlog_t dlog[$];

  // Divider model knobs
  int          lat = 5;
  bit          never = 1'b0;
  bit          hold_done = 1'b0;
  bit          resp_fixed = 1'b0;
  logic [31:0] resp_val = '0;

  int          n_starts = 0;
  int          start_cyc = 0;
  bit          running = 1'b0;
  int          dcnt = 0;
  int          my_lat = 0;
  bit          prev_start = 1'b0;
  logic [31:0] cap1 = '0, cap2 = '0;

  always @(negedge clk) begin
    dlog_t d;
    if (div_start) begin
      chk("start_one_cycle", 64'(prev_start), 64'(0));
      n_starts++;
      start_cyc = cyc;
      cap1 = div_in1;
      cap2 = div_in2;
      my_lat = lat;
      dcnt = 0;
      d.to   = never;
      d.q    = resp_fixed ? resp_val : $urandom;
      d.inf  = resp_fixed ? 1'b0 : 1'($urandom_range(0, 1));
      d.zero = resp_fixed ? 1'b0 : 1'($urandom_range(0, 1));
      d.a    = div_in1;
      d.b    = div_in2;
      dlog.push_back(d);
      div_out  = d.q;
      div_inf  = d.inf;
      div_zero = d.zero;
      div_done = hold_done && !never;
      running  = !never && !hold_done;
    end else if (running) begin
      dcnt++;
      if (reset_n && busy) begin
        chk("div_in1_stable", 64'(div_in1), 64'(cap1));
        chk("div_in2_stable", 64'(div_in2), 64'(cap2));
      end
      if (dcnt == my_lat) begin
        div_done = 1'b1;
        running  = 1'b0;
      end
    end
    prev_start = div_start;
  end

  // Output checker: compares every accepted result with the oldest expectation.
  bit          prev_hold = 1'b0;
  logic [35:0] prev_out = '0;
  bit          saw_ov = 1'b0;

  always @(negedge clk) begin
    exp_t  e;
    dlog_t d;
    logic [31:0] xq;
    bit xinf, xzero, xto;
    if (!reset_n) begin
      prev_hold = 1'b0;
      saw_ov = 1'b0;
      exp_q.delete();
      dlog.delete();
    end else begin
      if (out_valid) saw_ov = 1'b1;
      if (prev_hold)
        chk("out_held_stable", 64'({out_valid, out_timeout, out_zero, out_inf, out_q}), 64'(prev_out));
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_valid, out_timeout, out_zero, out_inf, out_q};
      if (out_valid && out_ready) begin
        chk("result_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          xq = e.q; xinf = e.inf; xzero = e.zero; xto = 1'b0;
          if (e.is_div) begin
            chk("div_issued", 64'(dlog.size() > 0), 64'(1));
            if (dlog.size() > 0) begin
              d = dlog.pop_front();
              chk("div_in1_operand", 64'(d.a), 64'(e.a));
              chk("div_in2_operand", 64'(d.b), 64'(e.b));
              if (d.to) begin
                xq = NAR; xinf = 1'b1; xzero = 1'b0; xto = 1'b1;
              end else begin
                xq = d.q; xinf = d.inf; xzero = d.zero;
              end
            end
          end
          chk("out_q", 64'(out_q), 64'(xq));
          chk("out_inf", 64'(out_inf), 64'(xinf));
          chk("out_zero", 64'(out_zero), 64'(xzero));
          chk("out_timeout", 64'(out_timeout), 64'(xto));
        end
      end
    end
  end

  // Sole driver of out_ready: random when rnd_ready, else ready_val; changes away from negedge.
  bit rnd_ready = 1'b0;
  bit ready_val = 1'b1;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  task automatic set_ready(input bit v);
    rnd_ready = 1'b0;
    ready_val = v;
    @(posedge clk);
    #2;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, output int acc);
    exp_t e;
    int t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("push_accepted", 64'(in_ready), 64'(1));
    acc = cyc;
    if (!in_ready) return;
    e.a = a; e.b = b; e.is_div = 1'b0; e.q = '0; e.inf = 1'b0; e.zero = 1'b0;
    if (a == NAR || b == NAR || b == 32'd0) begin
      e.q = NAR; e.inf = 1'b1;
    end else if (a == 32'd0) begin
      e.zero = 1'b1;
    end else begin
      e.is_div = 1'b1;
    end
    exp_q.push_back(e);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int bound, output int c);
    int t = 0;
    while (!out_valid && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid_within_bound", 64'(out_valid), 64'(1));
    c = cyc;
  endtask

  task automatic drain(input int bound);
    int t = 0;
    set_ready(1'b1);
    while ((exp_q.size() != 0 || busy) && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("drained", 64'(exp_q.size() == 0 && !busy), 64'(1));
    chk("div_log_empty", 64'(dlog.size()), 64'(0));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    v[31] = 1'b0;
    v[0]  = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] rand_any();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0) return NAR;
    if (k == 1) return 32'd0;
    return $urandom;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=running required=finished");
    $fatal(1);
  end

  initial begin
    int acc, c, s0;
    logic [31:0] sa[3];
    logic [31:0] sb[3];

    // Reset values
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_q", 64'(out_q), 64'(0));
    chk("rst_flags", 64'({out_inf, out_zero, out_timeout}), 64'(0));
    chk("rst_div_in", 64'({div_in1, div_in2}), 64'(0));
    chk("rst_div_start", 64'(div_start), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: normal divide, done 20 cycles after start
    resp_fixed = 1'b1; resp_val = 32'h6000_0000; lat = 20;
    s0 = n_starts;
    push(32'h7000_0000, 32'h6000_0000, acc);
    wait_ov(100, c);
    chk("t1_start_to_valid", 64'(c - start_cyc), 64'(21));
    chk("t1_accept_to_valid", 64'(c - acc), 64'(23));
    chk("t1_out_q", 64'(out_q), 64'(32'h6000_0000));
    chk("t1_starts", 64'(n_starts - s0), 64'(1));
    drain(100);

    // 2: special cases resolved locally
    resp_fixed = 1'b0;
    sa[0] = 32'h1234_5678; sb[0] = 32'h0000_0000;
    sa[1] = 32'h8000_0000; sb[1] = 32'h4000_0000;
    sa[2] = 32'h0000_0000; sb[2] = 32'h4000_0000;
    s0 = n_starts;
    for (int i = 0; i < 3; i++) begin
      push(sa[i], sb[i], acc);
      wait_ov(20, c);
      chk("t2_bypass_latency", 64'(c - acc), 64'(2));
      @(negedge clk);
    end
    chk("t2_no_starts", 64'(n_starts - s0), 64'(0));
    drain(50);

    // 3: done held high from the previous op
    hold_done = 1'b1;
    push(32'h7100_0000, 32'h6200_0000, acc);
    wait_ov(50, c);
    chk("t3_stale_done_latency", 64'(c - start_cyc), 64'(3));
    drain(50);
    hold_done = 1'b0;

    // 4: backpressure until the FIFO fills
    lat = 3;
    set_ready(1'b0);
    for (int i = 0; i < 5; i++) push(rand_operand(), rand_operand(), acc);
    chk("t4_in_ready_full", 64'(in_ready), 64'(0));
    chk("t4_busy", 64'(busy), 64'(1));
    repeat (8) @(negedge clk);
    chk("t4_in_ready_still_full", 64'(in_ready), 64'(0));
    set_ready(1'b1);
    push(rand_operand(), rand_operand(), acc);
    drain(300);

    // 5: watchdog abort, then a normal op
    never = 1'b1;
    push(rand_operand(), rand_operand(), acc);
    wait_ov(200, c);
    chk("t5_timeout_latency", 64'(c - start_cyc), 64'(TIMEOUT + 1));
    chk("t5_out_timeout", 64'(out_timeout), 64'(1));
    drain(50);
    never = 1'b0; lat = 4;
    push(rand_operand(), rand_operand(), acc);
    drain(100);

    // 6: reset during WAIT, done arrives later
    lat = 30;
    s0 = n_starts;
    push(rand_operand(), rand_operand(), acc);
    for (int t = 0; t < 20 && n_starts == s0; t++) @(negedge clk);
    chk("t6_started", 64'(n_starts - s0), 64'(1));
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_div_in", 64'({div_in1, div_in2}), 64'(0));
    chk("t6_rst_in_ready", 64'(in_ready), 64'(1));
    chk("t6_rst_out_q", 64'(out_q), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_no_out_valid", 64'(saw_ov), 64'(0));
    chk("t6_idle_busy", 64'(busy), 64'(0));

    // Randomized burst with random backpressure and latency
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(1, 8);
      if ($urandom_range(0, 2) == 0) push(rand_any(), rand_any(), acc);
      else                           push(rand_operand(), rand_operand(), acc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule

// File: doc/posit_div_issue_ctrl.md
Name: posit_div_issue_ctrl

Overview:
- Front-end controller for bct_posit_div.
- Accepts posit operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Resolves special cases (NaR, zero divisor, zero dividend) locally; issues all other pairs to the divider with a one-cycle start pulse, waits for done, and returns results on a valid/ready stream in request order.
- A watchdog aborts any divide that never completes.

Parameters:
- N, 32, posit word width (matches divider N).
- DEPTH, 4, operand FIFO entries (power of 2, >=2).
- TIMEOUT, 64, max cycles in WAIT before abort (>=4).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  N  dividend posit.
- in_b  in  N  divisor posit.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_q  out  N  quotient posit.
- out_inf  out  1  result is NaR.
- out_zero  out  1  result is zero.
- out_timeout  out  1  result produced by watchdog abort.
- div_in1  out  N  to divider in1; registered, held stable from start until done.
- div_in2  out  N  to divider in2; same holding rule.
- div_start  out  1  one-cycle start pulse.
- div_out  in  N  divider quotient.
- div_inf  in  1  divider inf flag.
- div_zero  in  1  divider zero flag.
- div_done  in  1  divider done (level; may stay high from the previous operation).
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async, reset_n low): FIFO empty, FSM IDLE, watchdog 0. in_ready=1, out_valid=0, out_q/div_in1/div_in2=0, out_inf/out_zero/out_timeout=0, div_start=0, busy=0.
- Reset asserted mid-divide: clears all state. Divider done/outputs are ignored until the next issued start.
- FIFO push when in_valid&&in_ready. Pop only in IDLE.
- Push to a full FIFO is impossible (in_ready=0). Push and pop in the same cycle are both allowed. Pointers are log2(DEPTH)+1 bits and wrap naturally.
- NaR = {1'b1,{N-1{1'b0}}}.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE, FIFO non-empty: pop the head and classify.
  - a==NaR, b==NaR, or b==0: result NaR, inf=1, zero=0; go to OUT.
  - a==0 (b valid): result 0, zero=1, inf=0; go to OUT.
  - Otherwise latch div_in1/div_in2 and go to ISSUE.
  - FIFO empty: stay in IDLE.
- ISSUE: div_start=1 for exactly this cycle; clear watchdog; go to WAIT.
- WAIT:
  - div_done is ignored in the first WAIT cycle (guards against stale done).
  - From the second WAIT cycle, div_done=1 captures div_out/div_inf/div_zero into output registers; go to OUT.
  - Watchdog increments every WAIT cycle. At count==TIMEOUT-1 without done: result NaR, inf=1, timeout=1; go to OUT.
  - done and timeout in the same cycle: done wins, timeout=0.
- OUT: out_valid=1, outputs held stable until out_ready. On handshake, clear flags and go to IDLE.
- Latency, empty FIFO, out_ready=1: in accept at cycle t → IDLE pop t+1 → ISSUE t+2 → WAIT from t+3 → out_valid the cycle after done is sampled. Bypass cases: out_valid at t+2.
- Results are strictly in arrival order; one divide is in flight at most.
- div_in1/div_in2 change only on the IDLE→ISSUE transition.

Decomposition:
- Shared package posit_div_pkg: NaR and zero constants as functions of N; FSM state enum (2-bit); helper function is_nar(word) / is_zero(word).
- One sub-module: posit_operand_fifo (2N-bit wide, DEPTH entries, push/pop/full/empty, registered storage). Controller FSM and watchdog stay in the top module.

Test Plan:
1. Normal divide: push a=0x70000000, b=0x60000000; divider model returns 0x60000000 with done 20 cycles after start → one div_start pulse, out_q=0x60000000, inf=0, zero=0, timeout=0; div_in1/div_in2 stable throughout WAIT.
2. Special cases: push (0x12345678, 0x00000000), (0x80000000, 0x40000000), (0x00000000, 0x40000000) → outputs NaR/inf, NaR/inf, 0/zero; no div_start pulses; each out_valid 2 cycles after accept.
3. Stale done: hold div_done=1 continuously from the previous op and issue a=0x71000000, b=0x62000000 → first WAIT cycle ignored; capture occurs on the second WAIT cycle, not in ISSUE.
4. Backpressure/full: out_ready=0, push 6 pairs back-to-back with DEPTH=4 → in_ready drops after the FIFO fills; no loss; release out_ready → 6 results in order.
5. Timeout: divider never asserts done → after TIMEOUT cycles out_q=0x80000000, inf=1, out_timeout=1. Next request proceeds normally.
6. Async reset during WAIT: assert reset_n low for 3 cycles → all outputs reset immediately; busy=0; a late div_done after reset produces no out_valid.
